pong_render: RTL

- Consumer end of the game-state interface: samples ball and paddle positions once per frame and draws them as 640x480@60 VGA pixels.
- Keeps the match score from the point_1/point_2 pulses and drives gameover back to the game state machine.
- frame_tick is a once-per-frame pulse the game logic may use as its update strobe.
- Sits between the game state machine and the board VGA connector; clk is the 25 MHz pixel clock.

---
 rtl/pong_pkg.sv | 36 +++
 rtl/vga_timing.sv | 49 ++++
 rtl/pong_render.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong display path: 640x480@60 timing, palette
// and game-coordinate width.
package pong_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_BALL   = 8'hFF;
    localparam logic [7:0] COL_P1     = 8'hE0;
    localparam logic [7:0] COL_P2     = 8'h03;
    localparam logic [7:0] COL_BORDER = 8'h92;

    // 12 bits signed so pos+PADDLE_HALF near 1023 cannot overflow before clipping
    typedef logic signed [11:0] coord_t;

    function automatic coord_t clip_game(input coord_t v);
        if (v < 12'sd0)
            return 12'sd0;
        if (v > coord_t'((1 << COORD_W) - 1))
            return coord_t'((1 << COORD_W) - 1);
        return v;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 raster counters with sync decode, visible flag and a
// registered frame_tick that is high while the counters sit at (0, 480).
module vga_timing
    import pong_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    output logic [9:0]   o_hcount,
    output logic [9:0]   o_vcount,
    output logic         o_hsync,
    output logic         o_vsync,
    output logic         o_visible,
    output logic         o_frame_tick
);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_frame_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (r_hcount == 10'(H_TOTAL - 1)) begin
                r_hcount <= '0;
                if (r_vcount == 10'(V_TOTAL - 1))
                    r_vcount <= '0;
                else
                    r_vcount <= r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
            r_frame_tick <= (r_hcount == 10'(H_TOTAL - 1)) &&
                            (r_vcount == 10'(V_VISIBLE - 1));
        end
    end

    assign o_hcount     = r_hcount;
    assign o_vcount     = r_vcount;
    assign o_hsync      = !((r_hcount >= 10'(H_VISIBLE + H_FRONT)) &&
                            (r_hcount <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign o_vsync      = !((r_vcount >= 10'(V_VISIBLE + V_FRONT)) &&
                            (r_vcount <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign o_visible    = (r_hcount < 10'(H_VISIBLE)) && (r_vcount < 10'(V_VISIBLE));
    assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/pong_render.sv
// Pong renderer: per-frame position snapshot, 3-stage pixel pipeline and score keeping.
// Optional score squares above the field are built when SCORE_DISPLAY_EN is defined.
module pong_render
    import pong_pkg::*;
#(
    parameter int FIELD_SHIFT = 2,
    parameter int FIELD_X0    = 192,
    parameter int FIELD_Y0    = 112,
    parameter int BALL_R      = 1,
    parameter int PADDLE_HALF = 8,
    parameter int WIN_SCORE   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] p1_pos,
    input  logic [COORD_W-1:0] p2_pos,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               point_1,
    input  logic               point_2,
    input  logic               clear_scores,
    output logic               hsync,
    output logic               vsync,
    output logic [7:0]         rgb,
    output logic               frame_tick,
    output logic [3:0]         score_1,
    output logic [3:0]         score_2,
    output logic               gameover
);

    localparam int     FIELD_W = (1 << COORD_W) >> FIELD_SHIFT;
    localparam coord_t L_X0    = coord_t'(FIELD_X0);
    localparam coord_t L_Y0    = coord_t'(FIELD_Y0);
    localparam coord_t L_XL    = L_X0 - 12'sd1;
    localparam coord_t L_XR    = L_X0 + coord_t'(FIELD_W);
    localparam coord_t L_YT    = L_Y0 - 12'sd1;
    localparam coord_t L_YB    = L_Y0 + coord_t'(FIELD_W);
    localparam coord_t L_R     = coord_t'(BALL_R);
    localparam coord_t L_PH    = coord_t'(PADDLE_HALF);
    localparam logic [3:0] L_WIN = 4'(WIN_SCORE);

    logic [9:0]         w_hcount, w_vcount;
    logic               w_hsync, w_vsync, w_visible, w_frame_tick;
    logic [COORD_W-1:0] r_p1, r_p2, r_x, r_y;
    coord_t             w_h, w_v, w_bx, w_by, w_p1_lo, w_p1_hi, w_p2_lo, w_p2_hi;
    logic               w_ball, w_p1, w_p2, w_border, w_s1, w_s2;
    logic               r1_vis, r1_ball, r1_p1, r1_p2, r1_border, r1_s1, r1_s2, r1_hs, r1_vs;
    logic               r2_hs, r2_vs;
    logic [7:0]         r_rgb;
    logic               r_pt1_d, r_pt2_d;
    logic [3:0]         r_score_1, r_score_2;
    logic               r_gameover;
    logic               w_rise1, w_rise2;

    vga_timing u_timing (
        .clk          (clk),
        .rst          (rst),
        .o_hcount     (w_hcount),
        .o_vcount     (w_vcount),
        .o_hsync      (w_hsync),
        .o_vsync      (w_vsync),
        .o_visible    (w_visible),
        .o_frame_tick (w_frame_tick)
    );

    function automatic coord_t to_scr(input coord_t g, input coord_t org);
        return org + (g >>> FIELD_SHIFT);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_x  <= '0;
            r_y  <= '0;
        end else if (w_frame_tick) begin
            r_p1 <= p1_pos;
            r_p2 <= p2_pos;
            r_x  <= x_pos;
            r_y  <= y_pos;
        end
    end

    assign w_h     = $signed({2'b00, w_hcount});
    assign w_v     = $signed({2'b00, w_vcount});
    assign w_bx    = to_scr($signed({2'b00, r_x}), L_X0);
    assign w_by    = to_scr($signed({2'b00, r_y}), L_Y0);
    assign w_p1_lo = to_scr(clip_game($signed({2'b00, r_p1}) - L_PH), L_Y0);
    assign w_p1_hi = to_scr(clip_game($signed({2'b00, r_p1}) + L_PH), L_Y0);
    assign w_p2_lo = to_scr(clip_game($signed({2'b00, r_p2}) - L_PH), L_Y0);
    assign w_p2_hi = to_scr(clip_game($signed({2'b00, r_p2}) + L_PH), L_Y0);

    assign w_ball   = (w_h >= w_bx - L_R) && (w_h <= w_bx + L_R) &&
                      (w_v >= w_by - L_R) && (w_v <= w_by + L_R);
    assign w_p1     = (w_h >= L_X0) && (w_h <= L_X0 + 12'sd3) &&
                      (w_v >= w_p1_lo) && (w_v <= w_p1_hi);
    assign w_p2     = (w_h >= L_XR - 12'sd4) && (w_h <= L_XR - 12'sd1) &&
                      (w_v >= w_p2_lo) && (w_v <= w_p2_hi);
    assign w_border = (((w_h == L_XL) || (w_h == L_XR)) && (w_v >= L_YT) && (w_v <= L_YB)) ||
                      (((w_v == L_YT) || (w_v == L_YB)) && (w_h >= L_XL) && (w_h <= L_XR));

    // Score squares: 4x4 with 2-pixel gaps, 16 rows above the field top
    always_comb begin
        w_s1 = 1'b0;
        w_s2 = 1'b0;
`ifdef SCORE_DISPLAY_EN
        if ((w_v >= L_Y0 - 12'sd16) && (w_v <= L_Y0 - 12'sd13)) begin
            for (int i = 0; i < WIN_SCORE; i++) begin
                if ((4'(i) < r_score_1) && (w_h >= L_X0 + coord_t'(6 * i)) &&
                    (w_h <= L_X0 + coord_t'(6 * i + 3)))
                    w_s1 = 1'b1;
                if ((4'(i) < r_score_2) && (w_h <= L_XR - 12'sd1 - coord_t'(6 * i)) &&
                    (w_h >= L_XR - 12'sd4 - coord_t'(6 * i)))
                    w_s2 = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_vis <= 1'b0; r1_ball <= 1'b0; r1_p1 <= 1'b0; r1_p2 <= 1'b0;
            r1_border <= 1'b0; r1_s1 <= 1'b0; r1_s2 <= 1'b0;
            r1_hs <= 1'b1; r1_vs <= 1'b1;
            r2_hs <= 1'b1; r2_vs <= 1'b1;
            r_rgb <= COL_BLACK;
        end else begin
            r1_vis <= w_visible; r1_ball <= w_ball; r1_p1 <= w_p1; r1_p2 <= w_p2;
            r1_border <= w_border; r1_s1 <= w_s1; r1_s2 <= w_s2;
            r1_hs <= w_hsync; r1_vs <= w_vsync;
            r2_hs <= r1_hs; r2_vs <= r1_vs;
            if (!r1_vis)        r_rgb <= COL_BLACK;
            else if (r1_ball)   r_rgb <= COL_BALL;
            else if (r1_s1)     r_rgb <= COL_P1;
            else if (r1_s2)     r_rgb <= COL_P2;
            else if (r1_p1)     r_rgb <= COL_P1;
            else if (r1_p2)     r_rgb <= COL_P2;
            else if (r1_border) r_rgb <= COL_BORDER;
            else                r_rgb <= COL_BLACK;
        end
    end

    assign w_rise1 = point_1 & ~r_pt1_d;
    assign w_rise2 = point_2 & ~r_pt2_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pt1_d    <= 1'b0;
            r_pt2_d    <= 1'b0;
            r_score_1  <= '0;
            r_score_2  <= '0;
            r_gameover <= 1'b0;
        end else begin
            r_pt1_d <= point_1;
            r_pt2_d <= point_2;
            if (clear_scores) begin
                r_score_1  <= '0;
                r_score_2  <= '0;
                r_gameover <= 1'b0;
            end else begin
                if (w_rise1 && (r_score_1 < L_WIN))
                    r_score_1 <= r_score_1 + 4'd1;
                if (w_rise2 && (r_score_2 < L_WIN))
                    r_score_2 <= r_score_2 + 4'd1;
                if ((r_score_1 == L_WIN) || (r_score_2 == L_WIN))
                    r_gameover <= 1'b1;
            end
        end
    end

    assign hsync      = r2_hs;
    assign vsync      = r2_vs;
    assign rgb        = r_rgb;
    assign frame_tick = w_frame_tick;
    assign score_1    = r_score_1;
    assign score_2    = r_score_2;
    assign gameover   = r_gameover;

endmodule
